nnet_output_framer: RTL

Downstream stage of the HLS neural-net layer. Accepts the layer's ap_fifo-style result stream (din/full_n/write, no packet framing), buffers it, and re-frames it into AXI-stream packets of a host-programmed length with a generated tlast. Each output packet carries the tuser header captured from the matching input packet. Output feeds the s_axis_data port of axi_wrapper.

---
 rtl/nnet_pkg.sv | 11 +
 rtl/nnet_fwft_fifo.sv | 55 +++++
 rtl/nnet_output_framer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/nnet_pkg.sv
// Shared constants and types for the nnet streaming stages.
package nnet_pkg;
    localparam logic [7:0] SR_SIZE_INPUT  = 8'd129;
    localparam logic [7:0] SR_SIZE_OUTPUT = 8'd130;
    localparam int         TUSER_W        = 128;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;
endpackage

// File: rtl/nnet_fwft_fifo.sv
// First-word-fall-through FIFO: o_dout shows the head entry whenever o_count is non-zero.
module nnet_fwft_fifo #(
    parameter int WIDTH  = 16,
    parameter int AWIDTH = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [WIDTH-1:0]  i_din,
    output logic [WIDTH-1:0]  o_dout,
    output logic [AWIDTH:0]   o_count
);
    localparam logic [AWIDTH:0]   DEPTH   = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0]   ONE_CNT = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH-1:0] ONE_PTR = {{(AWIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]  r_mem [2**AWIDTH];
    logic [AWIDTH-1:0] r_wr_ptr;
    logic [AWIDTH-1:0] r_rd_ptr;
    logic [AWIDTH:0]   r_count;
    logic              w_push;
    logic              w_pop;

    assign w_push  = i_push && (r_count != DEPTH);
    assign w_pop   = i_pop && (r_count != '0);
    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage is not reset; consumers gate o_dout with a non-zero count.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ONE_PTR;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ONE_PTR;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_CNT;
                2'b01:   r_count <= r_count - ONE_CNT;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/nnet_output_framer.sv
// Re-frames the HLS ap_fifo result stream into AXI-stream packets of programmable length,
// tagging each packet with the tuser header captured from the matching input packet.
module nnet_output_framer #(
    parameter int         WIDTH          = 16,
    parameter int         FIFO_AWIDTH    = 5,
    parameter logic [7:0] SR_SIZE_OUTPUT = 8'd130
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         set_stb,
    input  logic [7:0]                   set_addr,
    input  logic [31:0]                  set_data,
    input  logic [WIDTH-1:0]             hls_din,
    input  logic                         hls_write,
    output logic                         hls_full_n,
    input  logic [nnet_pkg::TUSER_W-1:0] i_tuser,
    input  logic                         i_tuser_valid,
    output logic                         i_tuser_ready,
    output logic [WIDTH-1:0]             o_tdata,
    output logic                         o_tlast,
    output logic                         o_tvalid,
    input  logic                         o_tready,
    output logic [nnet_pkg::TUSER_W-1:0] o_tuser,
    output logic                         err_overflow,
    output logic [31:0]                  pkt_count,
    output nnet_pkg::state_t             o_dbg_state
);
    import nnet_pkg::*;

    // Handshake: a beat transfers on a rising clk edge where o_tvalid && o_tready;
    // while o_tvalid && !o_tready, o_tdata/o_tlast/o_tuser hold and o_tvalid stays high.
    localparam logic [FIFO_AWIDTH:0] DATA_DEPTH = {1'b1, {FIFO_AWIDTH{1'b0}}};
    localparam logic [1:0]           HDR_DEPTH  = 2'd2;

    state_t               r_state;
    logic [31:0]          r_size;
    logic [31:0]          r_len;
    logic [31:0]          r_beat_cnt;
    logic [31:0]          r_pkt_count;
    logic                 r_live;
    logic                 r_err;
    logic [FIFO_AWIDTH:0] w_data_count;
    logic [1:0]           w_hdr_count;
    logic [WIDTH-1:0]     w_data_head;
    logic [TUSER_W-1:0]   w_hdr_head;
    logic                 w_data_full;
    logic                 w_hdr_full;
    logic                 w_data_push;
    logic                 w_hdr_push;
    logic                 w_stream;
    logic                 w_last;
    logic                 w_beat;
    logic                 w_overflow;

    // r_live keeps both ready signals low until the first edge after reset release.
    assign w_data_full   = (w_data_count == DATA_DEPTH);
    assign w_hdr_full    = (w_hdr_count == HDR_DEPTH);
    assign hls_full_n    = r_live && !w_data_full;
    assign i_tuser_ready = r_live && !w_hdr_full;
    assign w_data_push   = hls_write && hls_full_n;
    assign w_hdr_push    = i_tuser_valid && i_tuser_ready;
    assign w_overflow    = (hls_write && w_data_full) || (i_tuser_valid && w_hdr_full);

    assign w_stream      = (r_state == STREAM);
    assign w_last        = (r_beat_cnt == r_len - 32'd1);
    assign o_tvalid      = w_stream && (w_data_count != '0);
    assign o_tdata       = o_tvalid ? w_data_head : '0;
    assign o_tuser       = w_stream ? w_hdr_head : '0;
    assign o_tlast       = o_tvalid && w_last;
    assign w_beat        = o_tvalid && o_tready;
    assign err_overflow  = r_err;
    assign pkt_count     = r_pkt_count;
    assign o_dbg_state   = r_state;

    nnet_fwft_fifo #(.WIDTH(WIDTH), .AWIDTH(FIFO_AWIDTH)) u_data_fifo (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_clr   (clear),
        .i_push  (w_data_push),
        .i_pop   (w_beat),
        .i_din   (hls_din),
        .o_dout  (w_data_head),
        .o_count (w_data_count)
    );

    nnet_fwft_fifo #(.WIDTH(TUSER_W), .AWIDTH(1)) u_hdr_fifo (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_clr   (clear),
        .i_push  (w_hdr_push),
        .i_pop   (w_beat && w_last),
        .i_din   (i_tuser),
        .o_dout  (w_hdr_head),
        .o_count (w_hdr_count)
    );

    // The length setting survives clear; only reset_n restores it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_size <= 32'd1;
        end else if (set_stb && (set_addr == SR_SIZE_OUTPUT)) begin
            r_size <= set_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_len       <= 32'd1;
            r_beat_cnt  <= '0;
            r_pkt_count <= '0;
            r_err       <= 1'b0;
            r_live      <= 1'b0;
        end else if (clear) begin
            r_state     <= IDLE;
            r_len       <= 32'd1;
            r_beat_cnt  <= '0;
            r_pkt_count <= '0;
            r_err       <= 1'b0;
            r_live      <= 1'b1;
        end else begin
            r_live <= 1'b1;
            if (w_overflow) r_err <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_hdr_count != '0) begin
                        r_state    <= STREAM;
                        r_len      <= (r_size == '0) ? 32'd1 : r_size;
                        r_beat_cnt <= '0;
                    end
                end
                STREAM: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 32'd1;
                        if (w_last) begin
                            r_pkt_count <= r_pkt_count + 32'd1;
                            r_state     <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
